// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: register-file geometry, the zero-register
// index and the HI/LO write-operation encoding.
package cpu_pkg;

    localparam int REG_BITS  = 5;
    localparam int DATA_BITS = 32;

    localparam logic [REG_BITS-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        HILO_NONE   = 2'b00,
        HILO_MULDIV = 2'b01,
        HILO_MTHI   = 2'b10,
        HILO_MTLO   = 2'b11
    } hilo_op_e;

endpackage

// File: rtl/hilo_reg.sv
// HI/LO register pair with hilo_op decode. With REGFILE_BYPASS_EN defined,
// hi/lo show the value that will be committed at the coming edge.
module hilo_reg #(
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  cpu_pkg::hilo_op_e    hilo_op,
    input  logic [DATA_BITS-1:0] hilo_hi_in,
    input  logic [DATA_BITS-1:0] hilo_lo_in,
    input  logic [DATA_BITS-1:0] mt_data,
    output logic [DATA_BITS-1:0] hi,
    output logic [DATA_BITS-1:0] lo
);
    import cpu_pkg::*;

    logic [DATA_BITS-1:0] hi_q, lo_q;
    logic [DATA_BITS-1:0] hi_d, lo_d;
    logic                 fwd_on;

    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        unique case (hilo_op)
            HILO_MULDIV: begin
                hi_d = hilo_hi_in;
                lo_d = hilo_lo_in;
            end
            HILO_MTHI: hi_d = mt_data;
            HILO_MTLO: lo_d = mt_data;
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed during reset so outputs read zero.
    assign fwd_on = rst_n;
`else
    assign fwd_on = 1'b0;
`endif

    assign hi = fwd_on ? hi_d : hi_q;
    assign lo = fwd_on ? lo_d : lo_q;

endmodule

// File: rtl/regfile_hilo.sv
// MIPS architectural state: 32 GPRs (r0 reads zero) plus HI/LO.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_hilo #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_BITS-1:0] ra1,
    input  logic [ADDR_BITS-1:0] ra2,
    output logic [DATA_BITS-1:0] rd1,
    output logic [DATA_BITS-1:0] rd2,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] wa,
    input  logic [DATA_BITS-1:0] wd,
    input  logic [1:0]           hilo_op,
    input  logic [DATA_BITS-1:0] hilo_hi_in,
    input  logic [DATA_BITS-1:0] hilo_lo_in,
    input  logic [DATA_BITS-1:0] mt_data,
    output logic [DATA_BITS-1:0] hi,
    output logic [DATA_BITS-1:0] lo
);
    import cpu_pkg::*;

    localparam int NUM_REGS = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] ZERO_ADDR = ADDR_BITS'(REG_ZERO);

    logic [DATA_BITS-1:0] gpr [NUM_REGS];
    logic                 gpr_wr;
    logic                 fwd1, fwd2;

    assign gpr_wr = we && (wa != ZERO_ADDR);

    // NOTE: the whole array is cleared by the async reset because software
    // relies on every GPR reading zero after reset; this costs a reset on
    // each storage flop and rules out a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr[i] <= '0;
            end
        end else if (gpr_wr) begin
            gpr[wa] <= wd;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign fwd1 = rst_n && gpr_wr && (wa == ra1);
    assign fwd2 = rst_n && gpr_wr && (wa == ra2);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    // r0 is forced to zero on the read side; its storage is never written.
    assign rd1 = (ra1 == ZERO_ADDR) ? '0 : (fwd1 ? wd : gpr[ra1]);
    assign rd2 = (ra2 == ZERO_ADDR) ? '0 : (fwd2 ? wd : gpr[ra2]);

    hilo_reg #(
        .DATA_BITS (DATA_BITS)
    ) u_hilo_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .hilo_op    (hilo_op_e'(hilo_op)),
        .hilo_hi_in (hilo_hi_in),
        .hilo_lo_in (hilo_lo_in),
        .mt_data    (mt_data),
        .hi         (hi),
        .lo         (lo)
    );

endmodule

// File: tb/tb_regfile_hilo.sv
// Scoreboard bench for regfile_hilo: the driver pushes expected outputs from
// an array-based architectural model, a negedge monitor pops and compares.
module tb_regfile_hilo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ra1, ra2, wa;
    logic [31:0] rd1, rd2, wd, hilo_hi_in, hilo_lo_in, mt_data, hi, lo;
    logic        we;
    logic [1:0]  hilo_op;

    regfile_hilo #(.DATA_BITS(32), .ADDR_BITS(5)) dut (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we(we), .wa(wa), .wd(wd), .hilo_op(hilo_op),
        .hilo_hi_in(hilo_hi_in), .hilo_lo_in(hilo_lo_in), .mt_data(mt_data),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] rd1, rd2, hi, lo;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_gpr [32];
    logic [31:0] m_hi, m_lo;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] pend_hi(logic [1:0] op, logic [31:0] hin, logic [31:0] mt);
        if (op == 2'b01) return hin;
        if (op == 2'b10) return mt;
        return m_hi;
    endfunction

    function automatic logic [31:0] pend_lo(logic [1:0] op, logic [31:0] lin, logic [31:0] mt);
        if (op == 2'b01) return lin;
        if (op == 2'b11) return mt;
        return m_lo;
    endfunction

    function automatic logic [31:0] read_reg(logic [4:0] a, logic r, logic w,
                                             logic [4:0] waddr, logic [31:0] wdata);
        if (a == 0) return 32'h0;
        if (BYPASS && r && w && waddr == a) return wdata;
        return m_gpr[a];
    endfunction

    // Apply one cycle of inputs, predict outputs, then advance the model at the edge.
    task automatic apply(string name, logic r, logic [4:0] a1, logic [4:0] a2,
                         logic w, logic [4:0] waddr, logic [31:0] wdata,
                         logic [1:0] op, logic [31:0] hin, logic [31:0] lin,
                         logic [31:0] mt);
        exp_t e;
        rst_n = r; ra1 = a1; ra2 = a2; we = w; wa = waddr; wd = wdata;
        hilo_op = op; hilo_hi_in = hin; hilo_lo_in = lin; mt_data = mt;
        if (!r) begin
            foreach (m_gpr[i]) m_gpr[i] = 32'h0;
            m_hi = 32'h0;
            m_lo = 32'h0;
        end
        e.name = name;
        e.rd1  = read_reg(a1, r, w, waddr, wdata);
        e.rd2  = read_reg(a2, r, w, waddr, wdata);
        e.hi   = (BYPASS && r) ? pend_hi(op, hin, mt) : m_hi;
        e.lo   = (BYPASS && r) ? pend_lo(op, lin, mt) : m_lo;
        sb_q.push_back(e);
        @(posedge clk);
        if (r) begin
            if (w && waddr != 0) m_gpr[waddr] = wdata;
            m_hi = pend_hi(op, hin, mt);
            m_lo = pend_lo(op, lin, mt);
        end
        #1;
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.name, ".rd1"}, rd1, e.rd1);
            check({e.name, ".rd2"}, rd2, e.rd2);
            check({e.name, ".hi"},  hi,  e.hi);
            check({e.name, ".lo"},  lo,  e.lo);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; ra1 = '0; ra2 = '0; we = 1'b0; wa = '0; wd = '0;
        hilo_op = 2'b00; hilo_hi_in = '0; hilo_lo_in = '0; mt_data = '0;
        foreach (m_gpr[i]) m_gpr[i] = 32'h0;
        m_hi = 32'h0;
        m_lo = 32'h0;
        @(posedge clk);
        #1;

        apply("init_reset",  0, 5'd5, 5'd31, 0, 5'd0, 32'h0, 2'b00, 32'h0, 32'h0, 32'h0);
        apply("r0_write",    1, 5'd0, 5'd0,  1, 5'd0, 32'hDEADBEEF, 2'b00, 32'h0, 32'h0, 32'h0);
        apply("r0_read",     1, 5'd0, 5'd0,  0, 5'd0, 32'h0, 2'b00, 32'h0, 32'h0, 32'h0);
        apply("wr8_same",    1, 5'd8, 5'd8,  1, 5'd8, 32'h12345678, 2'b00, 32'h0, 32'h0, 32'h0);
        apply("rd8",         1, 5'd8, 5'd8,  0, 5'd0, 32'h0, 2'b00, 32'h0, 32'h0, 32'h0);
        apply("mult",        1, 5'd8, 5'd0,  0, 5'd0, 32'h0, 2'b01, 32'h00000001, 32'hFFFFFFFE, 32'h0);
        apply("mult_rd",     1, 5'd0, 5'd8,  0, 5'd0, 32'h0, 2'b00, 32'h0, 32'h0, 32'h0);
        apply("mtlo",        1, 5'd0, 5'd0,  0, 5'd0, 32'h0, 2'b11, 32'h0, 32'h0, 32'd7);
        apply("mtlo_rd",     1, 5'd0, 5'd0,  0, 5'd0, 32'h0, 2'b00, 32'h0, 32'h0, 32'h0);
        apply("wr3_mthi",    1, 5'd3, 5'd1,  1, 5'd3, 32'd9, 2'b10, 32'h0, 32'h0, 32'd5);
        apply("rd3",         1, 5'd3, 5'd8,  0, 5'd0, 32'h0, 2'b00, 32'h0, 32'h0, 32'h0);
        apply("wr5",         1, 5'd5, 5'd31, 1, 5'd5, 32'hA5A5A5A5, 2'b00, 32'h0, 32'h0, 32'h0);
        apply("wr31",        1, 5'd5, 5'd31, 1, 5'd31, 32'h5A5A5A5A, 2'b00, 32'h0, 32'h0, 32'h0);
        apply("rd5_31",      1, 5'd5, 5'd31, 0, 5'd0, 32'h0, 2'b00, 32'h0, 32'h0, 32'h0);
        apply("async_rst",   0, 5'd5, 5'd31, 0, 5'd0, 32'h0, 2'b00, 32'h0, 32'h0, 32'h0);
        apply("rd_after_rst",1, 5'd5, 5'd31, 0, 5'd0, 32'h0, 2'b00, 32'h0, 32'h0, 32'h0);
        apply("rst_mid_wr",  0, 5'd4, 5'd4,  1, 5'd4, 32'd77, 2'b01, 32'h11, 32'h22, 32'h0);
        apply("rd4_dropped", 1, 5'd4, 5'd0,  0, 5'd0, 32'h0, 2'b00, 32'h0, 32'h0, 32'h0);
        apply("wr4",         1, 5'd9, 5'd4,  1, 5'd4, 32'd77, 2'b00, 32'h0, 32'h0, 32'h0);
        apply("rd4",         1, 5'd4, 5'd4,  0, 5'd0, 32'h0, 2'b00, 32'h0, 32'h0, 32'h0);

        for (int n = 0; n < 400; n++) begin
            logic [4:0] a1, a2, waddr;
            a1    = 5'($urandom_range(0, 31));
            a2    = ($urandom_range(0, 7) == 0) ? a1 : 5'($urandom_range(0, 31));
            waddr = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31));
            apply("rand", ($urandom_range(0, 39) != 0), a1, a2,
                  1'($urandom_range(0, 1)), waddr, $urandom(),
                  2'($urandom_range(0, 3)), $urandom(), $urandom(), $urandom());
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
